// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: register-file
// geometry, well-known register indices and the basic word types.
package mips_pkg;

    localparam int NUM_GRF = 32;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regidx_t;

    localparam regidx_t REG_ZERO = 5'd0;
    localparam regidx_t REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/grf_read_port.sv
// One combinational read port of the GRF.
// The priority order is: reset, index 0, explicit bypass, internal
// write-through, then the stored array word.
module grf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] arr_word,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              bypass,
    output logic [DATA_W-1:0] rd
);

    // Read-priority mux; a bypass flag without we falls through to the array.
    always_comb begin
        rd = arr_word;
        if (reset) begin
            rd = '0;
        end else if (ra == '0) begin
            rd = '0;
        end else if (we && bypass) begin
            rd = wd;
        end else if (we && (wa == ra)) begin
            rd = wd;
        end
    end

endmodule : grf_read_port

// File: rtl/grf.sv
// General-purpose register file: 2^ADDR_W entries, $0 hardwired to zero,
// two combinational read ports with W-stage forwarding and one synchronous
// write port. Each committed write prints one log line in simulation.
module grf
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit LOG_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       pc_w,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              bypass_rs_grf,
    input  logic              bypass_rt_grf,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    // Entry 0 is never stored; the array starts at index 1.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];

    // Full-depth view with a constant zero in slot 0, used by the read ports.
    logic [DATA_W-1:0] regs_view [0:DEPTH-1];

    logic              commit;

    assign commit = !reset && we && (wa != '0);

    // Next-state of the array: reset clears everything, otherwise one write.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (reset) begin
                regs_d[i] = '0;
            end else if (we && (wa == i[ADDR_W-1:0])) begin
                regs_d[i] = wd;
            end
        end
    end

    // Register array state.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read view with $0 pinned to zero.
    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp1 (
        .reset    (reset),
        .ra       (ra1),
        .arr_word (regs_view[ra1]),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .bypass   (bypass_rs_grf),
        .rd       (rd1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp2 (
        .reset    (reset),
        .ra       (ra2),
        .arr_word (regs_view[ra2]),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .bypass   (bypass_rt_grf),
        .rd       (rd2)
    );

`ifndef SYNTHESIS
    generate
        if (LOG_EN) begin : g_log
            // One log line per committed architectural write.
            always_ff @(posedge clk) begin
                if (commit) begin
                    $display("@%08h: $%2d <= %08h", pc_w, wa, wd);
                end
            end
        end
    endgenerate

    // Flag a bypass request raised while no write is in flight.
    always_ff @(posedge clk) begin
        if (!reset && !we && (bypass_rs_grf || bypass_rt_grf)) begin
            $warning("grf: bypass flag raised with we=0 (rs=%0b rt=%0b)",
                     bypass_rs_grf, bypass_rt_grf);
        end
    end
`endif

endmodule : grf

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed scenarios followed by randomized
// traffic, all read data compared against a behavioural register model.
module tb_grf;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc_w;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        bypass_rs_grf;
    logic        bypass_rt_grf;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: architectural register contents.
    word_t model_regs [0:NUM_GRF-1];
    // Expected read data for the current vector, pushed then consumed in order.
    logic [31:0] exp_q [$];

    grf #(
        .DATA_W (32),
        .ADDR_W (5),
        .LOG_EN (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .we            (we),
        .wa            (wa),
        .wd            (wd),
        .pc_w          (pc_w),
        .ra1           (ra1),
        .ra2           (ra2),
        .bypass_rs_grf (bypass_rs_grf),
        .bypass_rt_grf (bypass_rt_grf),
        .rd1           (rd1),
        .rd2           (rd2)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h required %08h", tag, got, exp);
        end
    endtask

    // What a read port must return, straight from the read rules.
    function automatic word_t model_read(input logic r, input logic w, input regidx_t a_w,
                                         input word_t d_w, input regidx_t a_r, input logic byp);
        if (r)                           return '0;
        if (a_r == REG_ZERO)             return '0;
        if (w && (byp || a_w == a_r))    return d_w;
        return model_regs[a_r];
    endfunction

    // Effect of one clock edge on the architecture.
    task automatic model_edge(input logic r, input logic w, input regidx_t a_w, input word_t d_w);
        if (r) begin
            for (int i = 0; i < NUM_GRF; i++) model_regs[i] = '0;
        end else if (w && a_w != REG_ZERO) begin
            model_regs[a_w] = d_w;
        end
    endtask

    // Drive one cycle, check both ports before the edge, then advance.
    task automatic cycle(input string tag, input logic r, input logic w, input regidx_t a_w,
                         input word_t d_w, input word_t pc, input regidx_t a1, input regidx_t a2,
                         input logic b1, input logic b2);
        @(negedge clk);
        reset = r; we = w; wa = a_w; wd = d_w; pc_w = pc;
        ra1 = a1; ra2 = a2; bypass_rs_grf = b1; bypass_rt_grf = b2;
        exp_q.push_back(model_read(r, w, a_w, d_w, a1, b1));
        exp_q.push_back(model_read(r, w, a_w, d_w, a2, b2));
        #2;
        check_val({tag, ".rd1"}, rd1, exp_q.pop_front());
        check_val({tag, ".rd2"}, rd2, exp_q.pop_front());
        @(posedge clk);
        model_edge(r, w, a_w, d_w);
    endtask

    // Idle read of two indices.
    task automatic rd_cycle(input string tag, input regidx_t a1, input regidx_t a2);
        cycle(tag, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, a1, a2, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; pc_w = '0;
        ra1 = '0; ra2 = '0; bypass_rs_grf = 1'b0; bypass_rt_grf = 1'b0;
        for (int i = 0; i < NUM_GRF; i++) model_regs[i] = 'x;

        // Reset: outputs forced to zero while high, array cleared after.
        cycle("rst_hold", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd9, 1'b0, 1'b0);
        cycle("rst_hold2", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd1, 1'b0, 1'b0);

        // Preload, then a one-cycle reset must clear everything.
        for (int i = 1; i < NUM_GRF; i++)
            cycle("preload", 1'b0, 1'b1, 5'(i), $urandom, 32'h1000 + 32'(4*i), 5'(i), 5'(i), 1'b1, 1'b0);
        cycle("rst_pulse", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < NUM_GRF; i++) rd_cycle("rst_clear", 5'(i), 5'(31 - i));

        // Basic write then read back.
        cycle("wr8", 1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 32'h3000, 5'd1, 5'd2, 1'b0, 1'b0);
        rd_cycle("rd8", 5'd8, 5'd8);
        check_val("rd8_direct", rd1, 32'hDEADBEEF);

        // $0 protection, including a spurious bypass on index 0.
        cycle("wr0", 1'b0, 1'b1, 5'd0, 32'h1234, 32'h3004, 5'd0, 5'd0, 1'b1, 1'b1);
        rd_cycle("rd0", 5'd0, 5'd0);

        // Bypass and write-through to $ra.
        cycle("byp31", 1'b0, 1'b1, REG_RA, 32'h3008, 32'h3008, 5'd8, REG_RA, 1'b0, 1'b1);
        cycle("wt31", 1'b0, 1'b1, REG_RA, 32'h3008, 32'h300c, 5'd8, REG_RA, 1'b0, 1'b0);
        check_val("wt31_direct", rd2, 32'h3008);

        // Stale bypass flag with we low is ignored.
        cycle("wr5", 1'b0, 1'b1, 5'd5, 32'h7, 32'h3010, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("stale", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd8, 1'b1, 1'b0);
        check_val("stale_direct", rd1, 32'h7);

        // Reset wins over a same-cycle write; first write after release lands.
        cycle("wr3a", 1'b0, 1'b1, 5'd3, 32'h55, 32'h3014, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("rst_wr3", 1'b1, 1'b1, 5'd3, 32'h9, 32'h3018, 5'd3, 5'd3, 1'b1, 1'b0);
        rd_cycle("rd3_lost", 5'd3, 5'd3);
        check_val("rd3_lost_direct", rd1, 32'h0);
        cycle("wr3b", 1'b0, 1'b1, 5'd3, 32'h9, 32'h3018, 5'd3, 5'd4, 1'b0, 1'b0);
        rd_cycle("rd3_kept", 5'd3, 5'd0);
        check_val("rd3_kept_direct", rd1, 32'h9);

        // Back-to-back writes to one register: last one wins.
        cycle("b2b_a", 1'b0, 1'b1, 5'd12, 32'hAAAA0001, 32'h3020, 5'd12, 5'd12, 1'b0, 1'b0);
        cycle("b2b_b", 1'b0, 1'b1, 5'd12, 32'hBBBB0002, 32'h3024, 5'd12, 5'd12, 1'b0, 1'b0);
        rd_cycle("b2b_rd", 5'd12, 5'd12);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic    r, w, b1, b2;
            regidx_t a_w, a1, a2;
            word_t   d;
            r   = ($urandom_range(0, 49) == 0);
            w   = ($urandom_range(0, 3) != 0);
            a_w = 5'($urandom_range(0, 31));
            d   = $urandom;
            a1  = ($urandom_range(0, 2) == 0) ? a_w : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 2) == 0) ? a_w : 5'($urandom_range(0, 31));
            b1  = w && ((a1 == a_w) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0));
            b2  = w && ((a2 == a_w) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0));
            if (!w && $urandom_range(0, 99) == 0) b1 = 1'b1;
            cycle("rand", r, w, a_w, d, 32'h4000 + 32'(4*n), a1, a2, b1, b2);
        end

        // Final sweep of the whole array.
        for (int i = 0; i < NUM_GRF; i++) rd_cycle("sweep", 5'(i), 5'(i ^ 5'h1f));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_grf

// File: doc/grf.md
# grf

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers with two combinational read ports in the D stage and one synchronous write port driven from the W stage. It consumes `bypass_rs_grf` and `bypass_rt_grf` from the GRF-bypass control and substitutes the in-flight W-stage write data on the matching read port. `$0` is hardwired to zero. Each architectural write produces one simulation log line.

## Interface
Parameters:
- `DATA_W`, 32, register and port data width
- `ADDR_W`, 5, register index width; depth is 2^ADDR_W
- `LOG_EN`, 1, enables the per-write `$display` log line

Ports:
- `clk` input 1: rising-edge clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `we` input 1: W-stage write enable.
- `wa` input ADDR_W: W-stage destination register.
- `wd` input DATA_W: W-stage write data.
- `pc_w` input 32: PC of the W-stage instruction; used only for logging.
- `ra1` input ADDR_W: D-stage rs index.
- `ra2` input ADDR_W: D-stage rt index.
- `bypass_rs_grf` input 1: bypass controller's request to return `wd` on port 1.
- `bypass_rt_grf` input 1: bypass controller's request to return `wd` on port 2.
- `rd1` output DATA_W: rs read data.
- `rd2` output DATA_W: rt read data.

## Operation
- Storage: `regs[1..31]`. Index 0 is never stored and always reads 0.
- Write, at posedge `clk`:
  - If `reset`, every entry becomes 0.
  - Otherwise, if `we` and `wa != 0`, then `regs[wa] <= wd`.
  - Writes with `wa == 0` are discarded and produce no log line.
- Log: on every committed write with `LOG_EN = 1`, print `@<pc_w hex 8>: $<wa dec 2> <= <wd hex 8>`. The print happens at the clock edge, once per write.
- Read port n (n = 1, 2), priority highest first:
  1. `reset` high → 0.
  2. `ra_n == 0` → 0. This also covers a bypass flag raised spuriously for index 0.
  3. `we` and `bypass_n` → `wd`.
  4. `we` and `wa == ra_n` → `wd` (internal write-through; this makes the bypass flag redundant but harmless).
  5. Otherwise → `regs[ra_n]`.
- A bypass flag with `we = 0` is a protocol violation. It is ignored (rule 5 applies). In simulation, emit a `$warning`.
- Ports 1 and 2 are independent. Equal indices return identical data.

## Timing
- Read latency: 0 cycles (combinational from `ra_n`, `we`, `wa`, `wd`, the bypass flags and `reset`).
- Write latency: 1 cycle. Data written at edge k is visible through the array from edge k onward. Before edge k it is already visible through rules 3 and 4.
- Reset values:
  - All registers are 0 after the first edge with `reset` high.
  - `rd1` and `rd2` are 0 combinationally while `reset` is high.
- Reset asserted in the same cycle as a write: reset wins and the write is lost, with no log line.
- Reset released: the first write is accepted at the first edge with `reset` low.
- Back-to-back writes to the same register: last write wins, one log line per edge.
- No stall input. The upstream pipeline holds `we` low during bubbles.

## Structure
Shared package `mips_pkg`:
- `NUM_GRF = 32`
- `REG_ZERO = 5'd0`
- `REG_RA = 5'd31`
- type `word_t` (32-bit)
- type `regidx_t` (5-bit)

Sub-module `grf_read_port`, instantiated twice. It implements the read-priority mux from its inputs: index, array word, `we`, `wa`, `wd`, the bypass flag and `reset`. The top level holds the array, the write process and the log.

## Test plan
- **Reset clear:** preload via writes, then `reset=1` for 1 cycle → `rd1 = rd2 = 0` for every `ra` in 0..31.
- **Basic write/read:** `we=1, wa=8, wd=32'hDEADBEEF, pc_w=32'h3000` → log `@00003000: $ 8 <= deadbeef`; the next cycle `ra1=8` gives `rd1=32'hDEADBEEF`.
- **$0 protection:** `we=1, wa=0, wd=32'h1234` → no log; `ra1=0` gives 0, even with `bypass_rs_grf=1`.
- **Bypass/write-through:**
  - Same cycle, `we=1, wa=31, wd=32'h3008, ra2=31, bypass_rt_grf=1` → `rd2=32'h3008` before the edge.
  - Repeat with `bypass_rt_grf=0` → `rd2` still `32'h3008`.
- **Stale flag:** `we=0, bypass_rs_grf=1, ra1=5`, `regs[5]=7` → `rd1=7`, and the warning fires.
- **Reset vs write:** `reset=1, we=1, wa=3, wd=9` → `regs[3]=0`, no log. Then `reset=0` with the same write → `regs[3]=9`.
